preamble_inserter: RTL and testbench

Parametrised AXI4-Stream preamble inserter. It sits between a payload source and the stream egress of the preamble IP. A programmable table of up to MAX_PRE_LEN words is prepended to outgoing packets, either before every packet or once per enable. Configuration uses a simple register-style write port driven by the existing AXI4-Lite slave logic.

---
 rtl/preamble_pkg.sv | 19 +
 rtl/preamble_table.sv | 26 ++
 rtl/preamble_inserter.sv | 160 ++++++++++++++++
 tb/tb_preamble_inserter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_pkg.sv
// Shared types and helpers for the AXI4-Stream preamble inserter.
package preamble_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic lenValid(
    input int unsigned len,
    input int unsigned maxLen
  );
    return (len != 0) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/preamble_table.sv
// Preamble word store: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module preamble_table
  import preamble_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [AW-1:0]         wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [AW-1:0]         rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/preamble_inserter.sv
// AXI4-Stream preamble inserter: prepends a programmable word table
// to packets, per packet or once per enable.
module preamble_inserter
  import preamble_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_PRE_LEN = 16,
  parameter int LEN_W = $clog2(MAX_PRE_LEN + 1)
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           cfg_enable,
  input  logic                           cfg_mode,
  input  logic [LEN_W-1:0]               cfg_pre_len,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(MAX_PRE_LEN)-1:0] cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]          cfg_wr_data,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic                           busy,
  output logic [CNT_W-1:0]               pkt_count
);

  localparam int AW = $clog2(MAX_PRE_LEN);

  state_t                state;
  state_t                stateNxt;
  logic [AW-1:0]         idx;
  logic [AW-1:0]         idxNxt;
  logic [LEN_W-1:0]      lenSh;
  logic [LEN_W-1:0]      lenShNxt;
  logic                  modeSh;
  logic                  modeShNxt;
  logic                  armed;
  logic                  armedNxt;
  logic                  enPrev;
  logic [DATA_WIDTH-1:0] dataNxt;
  logic                  validNxt;
  logic                  lastNxt;
  logic                  userNxt;
  logic [CNT_W-1:0]      cntNxt;
  logic [DATA_WIDTH-1:0] tblWord;
  logic                  load;
  logic                  preDue;
  logic                  preDone;

  preamble_table #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_PRE_LEN)
  ) u_table (
    .clk   (ACLK),
    .wrEn  (cfg_wr_en),
    .wrAddr(cfg_wr_addr),
    .wrData(cfg_wr_data),
    .rdAddr(idx),
    .rdData(tblWord)
  );

  assign load = !m_axis_tvalid || m_axis_tready;
  assign busy = (state != IDLE);

  assign preDue = cfg_enable
                && lenValid(32'(cfg_pre_len), MAX_PRE_LEN)
                && (!cfg_mode || armed);

  assign preDone = (state == PREAMBLE) && load
                 && (LEN_W'(idx) == lenSh - LEN_W'(1));

  // Disable wins, then a fresh rising edge, then one-shot consumption
  always_comb begin
    armedNxt = armed;
    if (!cfg_enable)            armedNxt = 1'b0;
    else if (!enPrev)           armedNxt = 1'b1;
    else if (preDone && modeSh) armedNxt = 1'b0;
  end

  always_comb begin
    stateNxt      = state;
    idxNxt        = idx;
    lenShNxt      = lenSh;
    modeShNxt     = modeSh;
    dataNxt       = m_axis_tdata;
    validNxt      = m_axis_tvalid;
    lastNxt       = m_axis_tlast;
    userNxt       = m_axis_tuser;
    cntNxt        = pkt_count;
    s_axis_tready = 1'b0;
    if (load) validNxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          lenShNxt  = cfg_pre_len;
          modeShNxt = cfg_mode;
          idxNxt    = '0;
          stateNxt  = preDue ? PREAMBLE : PAYLOAD;
        end
      end
      PREAMBLE: begin
        if (load) begin
          validNxt = 1'b1;
          dataNxt  = tblWord;
          userNxt  = 1'b1;
          lastNxt  = 1'b0;
          if (preDone) stateNxt = PAYLOAD;
          else         idxNxt   = idx + AW'(1);
        end
      end
      PAYLOAD: begin
        s_axis_tready = load;
        if (load && s_axis_tvalid) begin
          validNxt = 1'b1;
          dataNxt  = s_axis_tdata;
          lastNxt  = s_axis_tlast;
          userNxt  = 1'b0;
          if (s_axis_tlast) begin
            stateNxt = IDLE;
            cntNxt   = pkt_count + CNT_W'(1);
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      idx           <= '0;
      lenSh         <= '0;
      modeSh        <= 1'b0;
      armed         <= 1'b0;
      enPrev        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      state         <= stateNxt;
      idx           <= idxNxt;
      lenSh         <= lenShNxt;
      modeSh        <= modeShNxt;
      armed         <= armedNxt;
      enPrev        <= cfg_enable;
      m_axis_tdata  <= dataNxt;
      m_axis_tvalid <= validNxt;
      m_axis_tlast  <= lastNxt;
      m_axis_tuser  <= userNxt;
      pkt_count     <= cntNxt;
    end
  end

endmodule

// File: tb/tb_preamble_inserter.sv
// Self-checking bench for preamble_inserter: vector table,
// directed corner sequences and randomized backpressure.
module tb_preamble_inserter;

  localparam int DW   = 32;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int AW   = 4;

  logic          tb_ACLK = 1'b0;
  logic          ARESET;
  logic          cfgEnable;
  logic          cfgMode;
  logic [LW-1:0] cfgPreLen;
  logic          cfgWrEn;
  logic [AW-1:0] cfgWrAddr;
  logic [DW-1:0] cfgWrData;
  logic [DW-1:0] sTdata;
  logic          sTvalid;
  logic          sTlast;
  logic          sTready;
  logic [DW-1:0] mTdata;
  logic          mTvalid;
  logic          mTlast;
  logic          mTuser;
  logic          mTready;
  logic          busy;
  logic [15:0]   pktCount;

  always #5 tb_ACLK = ~tb_ACLK;

  preamble_inserter #(
    .DATA_WIDTH (DW),
    .MAX_PRE_LEN(MAXL)
  ) dut (
    .ACLK         (tb_ACLK),
    .ARESET       (ARESET),
    .cfg_enable   (cfgEnable),
    .cfg_mode     (cfgMode),
    .cfg_pre_len  (cfgPreLen),
    .cfg_wr_en    (cfgWrEn),
    .cfg_wr_addr  (cfgWrAddr),
    .cfg_wr_data  (cfgWrData),
    .s_axis_tdata (sTdata),
    .s_axis_tvalid(sTvalid),
    .s_axis_tlast (sTlast),
    .s_axis_tready(sTready),
    .m_axis_tdata (mTdata),
    .m_axis_tvalid(mTvalid),
    .m_axis_tlast (mTlast),
    .m_axis_tuser (mTuser),
    .m_axis_tready(mTready),
    .busy         (busy),
    .pkt_count    (pktCount)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  typedef struct {
    logic          en;
    logic          mode;
    logic [LW-1:0] len;
    int            expPre;
  } vec_t;

  beat_t         got[$];
  beat_t         expQ[$];
  beat_t         srcQ[$];
  int            accCyc[$];
  logic [DW-1:0] tbl [MAXL];
  vec_t          vecs [8];
  int            nCmp = 0;
  int            nErr = 0;
  int            cyc = 0;
  int            expPkts = 0;
  bit            stall = 1'b0;
  beat_t         pb;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge tb_ACLK);
    cyc++;
  end

  // Output monitor plus hold-under-stall check
  initial forever begin
    beat_t b;
    @(negedge tb_ACLK);
    if (ARESET) begin
      stall = 1'b0;
    end else begin
      if (stall)
        check("stall_hold", 64'({mTvalid, mTuser, mTlast, mTdata}),
              64'({1'b1, pb.user, pb.last, pb.data}));
      if (mTvalid && mTready) begin
        b.data = mTdata;
        b.last = mTlast;
        b.user = mTuser;
        b.cyc  = cyc;
        got.push_back(b);
      end
      stall   = mTvalid && !mTready;
      pb.data = mTdata;
      pb.last = mTlast;
      pb.user = mTuser;
    end
  end

  task automatic wrTbl(input int a, input logic [DW-1:0] d);
    cfgWrEn   = 1'b1;
    cfgWrAddr = AW'(a);
    cfgWrData = d;
    tbl[a]    = d;
    @(posedge tb_ACLK); #2;
    cfgWrEn = 1'b0;
  endtask

  task automatic setCfg(input logic en, input logic mode, input int len);
    cfgEnable = en;
    cfgMode   = mode;
    cfgPreLen = LW'(len);
    @(posedge tb_ACLK); #2;
  endtask

  // Reference model: L table words (tuser=1), then the payload copied
  task automatic sendPkt(input int n, input int L);
    beat_t b;
    b.cyc = 0;
    for (int i = 0; i < L; i++) begin
      b.data = tbl[i];
      b.last = 1'b0;
      b.user = 1'b1;
      expQ.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      b.data = $urandom;
      b.last = (i == n - 1);
      b.user = 1'b0;
      srcQ.push_back(b);
      expQ.push_back(b);
    end
    expPkts++;
  endtask

  task automatic runTraffic(input bit randReady, input int stopAfter);
    int  guard = 0;
    int  drain = 0;
    bit  acc;
    forever begin
      if (srcQ.size() > 0) begin
        sTvalid = 1'b1;
        sTdata  = srcQ[0].data;
        sTlast  = srcQ[0].last;
      end else begin
        sTvalid = 1'b0;
      end
      mTready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge tb_ACLK);
      acc = sTvalid && sTready;
      if (acc) accCyc.push_back(cyc);
      @(posedge tb_ACLK); #2;
      if (acc) void'(srcQ.pop_front());
      guard++;
      if (stopAfter > 0 && got.size() >= stopAfter) break;
      if (srcQ.size() == 0 && got.size() >= expQ.size()) drain++;
      if (drain >= 3) break;
      if (guard > 3000) begin
        nCmp++;
        nErr++;
        $display("FAIL traffic_timeout: got %0d beats expected %0d",
                 got.size(), expQ.size());
        break;
      end
    end
    sTvalid = 1'b0;
    mTready = 1'b1;
  endtask

  task automatic checkQ(input string name);
    check({name, "_beats"}, 64'(got.size()), 64'(expQ.size()));
    for (int i = 0; i < got.size() && i < expQ.size(); i++)
      check($sformatf("%s_beat%0d", name, i),
            64'({got[i].user, got[i].last, got[i].data}),
            64'({expQ[i].user, expQ[i].last, expQ[i].data}));
  endtask

  task automatic clr();
    got.delete();
    expQ.delete();
    srcQ.delete();
    accCyc.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, LW'(3),  3};
    vecs[1] = '{1'b0, 1'b0, LW'(3),  0};
    vecs[2] = '{1'b1, 1'b0, LW'(0),  0};
    vecs[3] = '{1'b1, 1'b0, LW'(17), 0};
    vecs[4] = '{1'b1, 1'b0, LW'(16), 16};
    vecs[5] = '{1'b1, 1'b0, LW'(1),  1};
    vecs[6] = '{1'b0, 1'b1, LW'(5),  0};
    vecs[7] = '{1'b1, 1'b1, LW'(2),  2};

    ARESET    = 1'b1;
    cfgEnable = 1'b0;
    cfgMode   = 1'b0;
    cfgPreLen = '0;
    cfgWrEn   = 1'b0;
    cfgWrAddr = '0;
    cfgWrData = '0;
    sTdata    = '0;
    sTvalid   = 1'b0;
    sTlast    = 1'b0;
    mTready   = 1'b1;
    repeat (3) @(posedge tb_ACLK);
    #2;
    check("rst_tvalid", 64'(mTvalid), 0);
    check("rst_tdata",  64'(mTdata),  0);
    check("rst_tlast",  64'(mTlast),  0);
    check("rst_tuser",  64'(mTuser),  0);
    check("rst_sready", 64'(sTready), 0);
    check("rst_busy",   64'(busy),    0);
    check("rst_pktcnt", 64'(pktCount), 0);
    ARESET = 1'b0;
    @(posedge tb_ACLK); #2;

    for (int i = 0; i < MAXL; i++)
      wrTbl(i, (i < 3) ? 32'hA0 + DW'(i) : $urandom);

    // Mode 0, two packets, 3-word preamble on each
    setCfg(1'b1, 1'b0, 3);
    sendPkt(2, 3);
    sendPkt(2, 3);
    runTraffic(1'b0, 0);
    checkQ("m0");
    check("m0_pktcnt", 64'(pktCount), 64'(expPkts));
    clr();

    // Mode 1: one-shot, then re-arm by pulsing enable
    setCfg(1'b0, 1'b1, 2);
    setCfg(1'b1, 1'b1, 2);
    sendPkt(1, 2);
    sendPkt(1, 0);
    sendPkt(1, 0);
    runTraffic(1'b0, 0);
    checkQ("m1");
    clr();
    setCfg(1'b0, 1'b1, 2);
    setCfg(1'b1, 1'b1, 2);
    sendPkt(1, 2);
    runTraffic(1'b0, 0);
    checkQ("m1_rearm");
    clr();

    for (int v = 0; v < 8; v++) begin
      setCfg(1'b0, vecs[v].mode, int'(vecs[v].len));
      setCfg(vecs[v].en, vecs[v].mode, int'(vecs[v].len));
      sendPkt(2, vecs[v].expPre);
      runTraffic(1'b0, 0);
      checkQ($sformatf("vec%0d", v));
      if (got.size() > vecs[v].expPre && accCyc.size() > 0) begin
        check($sformatf("vec%0d_lat", v),
              64'(got[vecs[v].expPre].cyc - accCyc[0]), 1);
        check($sformatf("vec%0d_span", v),
              64'(got[got.size()-1].cyc - got[0].cyc),
              64'(vecs[v].expPre + 1));
      end
      clr();
    end

    // Random backpressure, 4-word preamble, 5-beat packets
    setCfg(1'b1, 1'b0, 4);
    for (int p = 0; p < 6; p++) sendPkt(5, 4);
    runTraffic(1'b1, 0);
    checkQ("bp");
    clr();

    for (int r = 0; r < 3; r++) begin
      int L;
      L = $urandom_range(1, MAXL);
      for (int i = 0; i < 4; i++) wrTbl($urandom_range(0, MAXL - 1), $urandom);
      setCfg(1'b1, 1'b0, L);
      for (int p = 0; p < 4; p++) sendPkt($urandom_range(1, 6), L);
      runTraffic(1'b1, 0);
      checkQ($sformatf("rnd%0d", r));
      clr();
    end
    check("rnd_pktcnt", 64'(pktCount), 64'(expPkts));

    // Reset after two of four preamble words
    setCfg(1'b1, 1'b0, 4);
    sendPkt(3, 4);
    runTraffic(1'b0, 2);
    ARESET = 1'b1;
    #1;
    check("mid_tvalid", 64'(mTvalid), 0);
    check("mid_tdata",  64'(mTdata),  0);
    check("mid_tlast",  64'(mTlast),  0);
    check("mid_tuser",  64'(mTuser),  0);
    check("mid_sready", 64'(sTready), 0);
    check("mid_busy",   64'(busy),    0);
    check("mid_pktcnt", 64'(pktCount), 0);
    clr();
    expPkts = 0;
    @(posedge tb_ACLK); #2;
    ARESET = 1'b0;
    @(posedge tb_ACLK); #2;
    sendPkt(2, 4);
    runTraffic(1'b0, 0);
    checkQ("post_rst");
    check("post_rst_pktcnt", 64'(pktCount), 64'(expPkts));
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
